// File: rtl/attention_qkt_seq_if.sv
// rtl/attention_qkt_seq_if.sv - start/busy/done handshake and matrix bus of the QK^T score engine
interface attention_qkt_seq_if #(
    parameter int SEQ_LEN = 4,
    parameter int D_MODEL = 16,
    parameter int DATA_W  = 8
);
    localparam int S_W = 2 * DATA_W + $clog2(D_MODEL);

    logic                                start;
    logic                                clear;
    logic [SEQ_LEN*D_MODEL*DATA_W-1:0]   I;
    logic [D_MODEL*D_MODEL*DATA_W-1:0]   WQ;
    logic [D_MODEL*D_MODEL*DATA_W-1:0]   WK;
    logic                                busy;
    logic                                done;
    logic [SEQ_LEN*D_MODEL*DATA_W-1:0]   Q;
    logic [SEQ_LEN*D_MODEL*DATA_W-1:0]   K;
    logic [SEQ_LEN*SEQ_LEN*S_W-1:0]      S;

    modport master (output start, clear, I, WQ, WK, input busy, done, Q, K, S);
    modport slave  (input start, clear, I, WQ, WK, output busy, done, Q, K, S);
endinterface

// File: rtl/attention_qkt_seq.sv
// rtl/attention_qkt_seq.sv - sequential Q=I*WQ, K=I*WK, S=Q*K^T engine; ATTN_CAUSAL_MASK_EN enables causal mask
module attention_qkt_seq #(
    parameter int SEQ_LEN   = 4,
    parameter int D_MODEL   = 16,
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    attention_qkt_seq_if.slave   bus
);
    localparam int S_W     = 2 * DATA_W + $clog2(D_MODEL);
    localparam int RW      = $clog2(SEQ_LEN);
    localparam int NW      = $clog2(D_MODEL);
    // c walks K columns during CALC_QK and score columns j during CALC_S
    localparam int CW      = (NW > RW) ? NW : RW;
    localparam int QK_BITS = SEQ_LEN * D_MODEL * DATA_W;
    localparam int W_BITS  = D_MODEL * D_MODEL * DATA_W;
    localparam int S_BITS  = SEQ_LEN * SEQ_LEN * S_W;

    localparam logic signed [S_W-1:0] SAT_MAX = S_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [S_W-1:0] SAT_MIN = S_W'(-(1 <<< (DATA_W - 1)));
    localparam logic [S_W-1:0]        S_NEG   = {1'b1, {(S_W-1){1'b0}}};
    localparam logic [NW-1:0]         N_LAST  = NW'(D_MODEL - 1);
    localparam logic [RW-1:0]         R_LAST  = RW'(SEQ_LEN - 1);
    localparam logic [CW-1:0]         C_LAST  = CW'(D_MODEL - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC_QK, CALC_S, DONE} state_t;

    state_t                  state_q;
    logic [QK_BITS-1:0]      i_op_q;
    logic [W_BITS-1:0]       wq_op_q;
    logic [W_BITS-1:0]       wk_op_q;
    logic [QK_BITS-1:0]      q_w_q;
    logic [QK_BITS-1:0]      k_w_q;
    logic [S_BITS-1:0]       s_w_q;
    logic [QK_BITS-1:0]      q_out_q;
    logic [QK_BITS-1:0]      k_out_q;
    logic [S_BITS-1:0]       s_out_q;
    logic [RW-1:0]           r_q;
    logic [CW-1:0]           c_q;
    logic [NW-1:0]           n_q;
    logic signed [S_W-1:0]   acc_a_q;
    logic signed [S_W-1:0]   acc_b_q;
    logic signed [S_W-1:0]   acc_a_d;
    logic signed [S_W-1:0]   acc_b_d;
    logic                    busy_q;
    logic                    done_q;

    int                      a_idx;
    int                      w_idx;
    int                      kj_idx;
    int                      qk_idx;
    int                      s_idx;
    logic                    row_end;
    logic signed [DATA_W-1:0]   mul_a_x;
    logic signed [DATA_W-1:0]   mul_a_y;
    logic signed [DATA_W-1:0]   mul_b_x;
    logic signed [DATA_W-1:0]   mul_b_y;
    logic signed [2*DATA_W-1:0] prod_a;
    logic signed [2*DATA_W-1:0] prod_b;

    // rescale a Q/K accumulator and clamp it into the DATA_W signed range
    function automatic logic [DATA_W-1:0] sat(input logic signed [S_W-1:0] x);
        logic signed [S_W-1:0] sh;
        sh = x >>> FRAC_BITS;
        if (sh > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return sh[DATA_W-1:0];
    endfunction

    // shared MAC: lane A computes Q terms, then is reused for S terms; lane B computes K terms
    always_comb begin
        a_idx  = int'(r_q) * D_MODEL + int'(n_q);
        w_idx  = int'(n_q) * D_MODEL + int'(c_q);
        kj_idx = int'(c_q) * D_MODEL + int'(n_q);
        qk_idx = int'(r_q) * D_MODEL + int'(c_q);
        s_idx  = int'(r_q) * SEQ_LEN + int'(c_q);
        mul_b_x = i_op_q[a_idx*DATA_W +: DATA_W];
        mul_b_y = wk_op_q[w_idx*DATA_W +: DATA_W];
        if (state_q == CALC_S) begin
            mul_a_x = q_w_q[a_idx*DATA_W +: DATA_W];
            mul_a_y = k_w_q[kj_idx*DATA_W +: DATA_W];
        end else begin
            mul_a_x = i_op_q[a_idx*DATA_W +: DATA_W];
            mul_a_y = wq_op_q[w_idx*DATA_W +: DATA_W];
        end
        prod_a  = mul_a_x * mul_a_y;
        prod_b  = mul_b_x * mul_b_y;
        acc_a_d = acc_a_q + S_W'(prod_a);
        acc_b_d = acc_b_q + S_W'(prod_b);
`ifdef ATTN_CAUSAL_MASK_EN
        // only the lower triangle (j<=i) is computed; the rest stays masked
        row_end = (int'(c_q) == int'(r_q));
`else
        row_end = (int'(c_q) == SEQ_LEN - 1);
`endif
    end

    // control FSM with the working matrices, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_op_q  <= '0;
            wq_op_q <= '0;
            wk_op_q <= '0;
            q_w_q   <= '0;
            k_w_q   <= '0;
            s_w_q   <= '0;
            q_out_q <= '0;
            k_out_q <= '0;
            s_out_q <= '0;
            r_q     <= '0;
            c_q     <= '0;
            n_q     <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            i_op_q  <= bus.I;
                            wq_op_q <= bus.WQ;
                            wk_op_q <= bus.WK;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                        n_q     <= '0;
`ifdef ATTN_CAUSAL_MASK_EN
                        s_w_q   <= {(SEQ_LEN*SEQ_LEN){S_NEG}};
`endif
                        state_q <= CALC_QK;
                    end
                    CALC_QK: begin
                        if (n_q == N_LAST) begin
                            q_w_q[qk_idx*DATA_W +: DATA_W] <= sat(acc_a_d);
                            k_w_q[qk_idx*DATA_W +: DATA_W] <= sat(acc_b_d);
                            acc_a_q <= '0;
                            acc_b_q <= '0;
                            n_q     <= '0;
                            if (c_q == C_LAST) begin
                                c_q <= '0;
                                if (r_q == R_LAST) begin
                                    r_q     <= '0;
                                    state_q <= CALC_S;
                                end else begin
                                    r_q <= r_q + RW'(1);
                                end
                            end else begin
                                c_q <= c_q + CW'(1);
                            end
                        end else begin
                            acc_a_q <= acc_a_d;
                            acc_b_q <= acc_b_d;
                            n_q     <= n_q + NW'(1);
                        end
                    end
                    CALC_S: begin
                        if (n_q == N_LAST) begin
                            s_w_q[s_idx*S_W +: S_W] <= acc_a_d;
                            acc_a_q <= '0;
                            n_q     <= '0;
                            if (row_end) begin
                                c_q <= '0;
                                if (r_q == R_LAST) begin
                                    r_q     <= '0;
                                    state_q <= DONE;
                                end else begin
                                    r_q <= r_q + RW'(1);
                                end
                            end else begin
                                c_q <= c_q + CW'(1);
                            end
                        end else begin
                            acc_a_q <= acc_a_d;
                            n_q     <= n_q + NW'(1);
                        end
                    end
                    DONE: begin
                        q_out_q <= q_w_q;
                        k_out_q <= k_w_q;
                        s_out_q <= s_w_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = q_out_q;
    assign bus.K    = k_out_q;
    assign bus.S    = s_out_q;
endmodule

// File: tb/tb_attention_qkt_seq.sv
// tb/tb_attention_qkt_seq.sv - directed self-checking bench for attention_qkt_seq
module tb_attention_qkt_seq;
    localparam int SL = 4;
    localparam int DM = 16;
    localparam int DW = 8;
    localparam int SW = 2 * DW + $clog2(DM);
    localparam int QB = SL * DM * DW;
    localparam int WB = DM * DM * DW;
    localparam int SB = SL * SL * SW;
`ifdef ATTN_CAUSAL_MASK_EN
    localparam bit MASK = 1'b1;
    localparam int LS   = SL * (SL + 1) / 2 * DM;
`else
    localparam bit MASK = 1'b0;
    localparam int LS   = SL * SL * DM;
`endif
    localparam int LAT = 2 + SL * DM * DM + LS;
    localparam logic [SW-1:0] S_NEG = {1'b1, {(SW-1){1'b0}}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    attention_qkt_seq_if #(.SEQ_LEN(SL), .D_MODEL(DM), .DATA_W(DW)) bus ();
    attention_qkt_seq_if #(.SEQ_LEN(SL), .D_MODEL(DM), .DATA_W(DW)) bus4 ();

    attention_qkt_seq #(.SEQ_LEN(SL), .D_MODEL(DM), .DATA_W(DW), .FRAC_BITS(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    attention_qkt_seq #(.SEQ_LEN(SL), .D_MODEL(DM), .DATA_W(DW), .FRAC_BITS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [QB-1:0] rows_const(input int scale);
        logic [QB-1:0] v;
        v = '0;
        for (int r = 0; r < SL; r++)
            for (int c = 0; c < DM; c++)
                v[(r*DM+c)*DW +: DW] = DW'(scale * (r + 1));
        return v;
    endfunction

    function automatic logic [QB-1:0] fill_i(input int val);
        logic [QB-1:0] v;
        for (int e = 0; e < SL * DM; e++) v[e*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [WB-1:0] fill_w(input int val);
        logic [WB-1:0] v;
        for (int e = 0; e < DM * DM; e++) v[e*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [WB-1:0] diag(input int val);
        logic [WB-1:0] v;
        v = '0;
        for (int n = 0; n < DM; n++) v[(n*DM+n)*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [SB-1:0] score_outer(input int scale);
        logic [SB-1:0] v;
        for (int i = 0; i < SL; i++)
            for (int j = 0; j < SL; j++)
                v[(i*SL+j)*SW +: SW] = (MASK && j > i) ? S_NEG : SW'(scale * (i + 1) * (j + 1));
        return v;
    endfunction

    function automatic logic [SB-1:0] score_const(input int val);
        logic [SB-1:0] v;
        for (int i = 0; i < SL; i++)
            for (int j = 0; j < SL; j++)
                v[(i*SL+j)*SW +: SW] = (MASK && j > i) ? S_NEG : SW'(val);
        return v;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.done && cyc < 5000);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;
        int idle_cnt;
        int t0;
        int t1;
        logic [SW-1:0] sv;

        bus.start  = 1'b0; bus.clear  = 1'b0; bus.I  = '0; bus.WQ  = '0; bus.WK  = '0;
        bus4.start = 1'b0; bus4.clear = 1'b0; bus4.I = '0; bus4.WQ = '0; bus4.WK = '0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 512'(bus.busy), 512'(1'b0));
        chk("rst_done", 512'(bus.done), 512'(1'b0));
        chk("rst_q", 512'(bus.Q), '0);
        chk("rst_k", 512'(bus.K), '0);
        chk("rst_s", 512'(bus.S), '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // identity weights; second instance checks the FRAC_BITS=4 rescale with negatives
        bus.I   = rows_const(1);  bus.WQ  = diag(1);  bus.WK  = diag(1);
        bus4.I  = rows_const(1);  bus4.WQ = diag(16); bus4.WK = diag(-16);
        bus.start = 1'b1; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus4.start = 1'b0;
        chk("id_busy", 512'(bus.busy), 512'(1'b1));
        bus.I = '1; bus.WQ = '1; bus.WK = '1;
        bus4.I = '1; bus4.WQ = '1; bus4.WK = '1;
        wait_done(cyc);
        chk("id_latency", 512'(cyc), 512'(LAT));
        chk("id_done4", 512'(bus4.done), 512'(1'b1));
        chk("id_q", 512'(bus.Q), 512'(rows_const(1)));
        chk("id_k", 512'(bus.K), 512'(rows_const(1)));
        chk("id_s", 512'(bus.S), 512'(score_outer(16)));
        sv = 20'd256;
        chk("id_s33", 512'(bus.S[15*SW +: SW]), 512'(sv));
        sv = MASK ? S_NEG : 20'd32;
        chk("id_s01", 512'(bus.S[1*SW +: SW]), 512'(sv));
        sv = 20'd32;
        chk("id_s10", 512'(bus.S[4*SW +: SW]), 512'(sv));
        chk("fr_q", 512'(bus4.Q), 512'(rows_const(1)));
        chk("fr_k", 512'(bus4.K), 512'(rows_const(-1)));
        chk("fr_s", 512'(bus4.S), 512'(score_outer(-16)));
        @(posedge clk);
        #1;
        chk("id_done_width", 512'(bus.done), 512'(1'b0));
        chk("id_busy_after", 512'(bus.busy), 512'(1'b0));

        // saturation of Q and K, full-precision S
        bus.I = fill_i(127); bus.WQ = fill_w(127); bus.WK = fill_w(-128);
        pulse_start();
        wait_done(cyc);
        chk("sat_done", 512'(bus.done), 512'(1'b1));
        chk("sat_q", 512'(bus.Q), 512'(fill_i(127)));
        chk("sat_k", 512'(bus.K), 512'(fill_i(-128)));
        chk("sat_s", 512'(bus.S), 512'(score_const(-260096)));
        sv = 20'hC0800;
        chk("sat_s00", 512'(bus.S[0 +: SW]), 512'(sv));

        // start held high: back-to-back runs
        bus.start = 1'b1;
        pulses = 0; idle_cnt = 0; t0 = 0; t1 = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) t0 = n;
                if (pulses == 2) t1 = n;
            end
            if (!bus.busy) idle_cnt++;
        end
        bus.start = 1'b0;
        chk("hs_pulses", 512'(pulses), 512'(2));
        chk("hs_first", 512'(t0), 512'(LAT + 1));
        chk("hs_spacing", 512'(t1 - t0), 512'(LAT + 1));
        chk("hs_idle", 512'(idle_cnt), 512'(2));
        chk("hs_s", 512'(bus.S), 512'(score_const(-260096)));
        wait_done(cyc);
        chk("hs_drain", 512'(bus.done), 512'(1'b1));

        // abort in CALC_S, outputs retained, then restart
        bus.I = rows_const(1); bus.WQ = diag(1); bus.WK = diag(1);
        pulse_start();
        repeat (SL * DM * DM + 30) @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        chk("ab_busy", 512'(bus.busy), 512'(1'b0));
        pulses = 0;
        for (int n = 0; n < LAT + 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("ab_nodone", 512'(pulses), 512'(0));
        chk("ab_q", 512'(bus.Q), 512'(fill_i(127)));
        chk("ab_k", 512'(bus.K), 512'(fill_i(-128)));
        chk("ab_s", 512'(bus.S), 512'(score_const(-260096)));
        bus.start = 1'b1; bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.clear = 1'b0;
        chk("clr_prio", 512'(bus.busy), 512'(1'b0));
        pulse_start();
        wait_done(cyc);
        chk("rs_latency", 512'(cyc), 512'(LAT));
        chk("rs_q", 512'(bus.Q), 512'(rows_const(1)));
        chk("rs_s", 512'(bus.S), 512'(score_outer(16)));

        // reset mid CALC_QK
        bus.I = fill_i(127); bus.WQ = fill_w(127); bus.WK = fill_w(-128);
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_busy", 512'(bus.busy), 512'(1'b0));
        chk("mr_done", 512'(bus.done), 512'(1'b0));
        chk("mr_q", 512'(bus.Q), '0);
        chk("mr_k", 512'(bus.K), '0);
        chk("mr_s", 512'(bus.S), '0);
        chk("mr_q4", 512'(bus4.Q), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_idle", 512'(bus.busy), 512'(1'b0));
        pulse_start();
        chk("mr_accept", 512'(bus.busy), 512'(1'b1));
        wait_done(cyc);
        chk("mr_latency", 512'(cyc), 512'(LAT));
        chk("mr_q_run", 512'(bus.Q), 512'(fill_i(127)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
